// File: rtl/propose_seq_pkg.sv
// -----------------------------------------------------------------------------
// propose_seq_pkg
// Shared types and constants for the propose-move sequencer slice.
//   - state_t        : sequencer FSM states
//   - CW / ASSIGN_W  : clause-word and assignment widths for the default build
//   - calc_cw/aw     : the same widths for any parameterisation
//   - LFSR_SEED/TAPS : 16-bit Fibonacci LFSR constants (taps 16,14,13,11)
// -----------------------------------------------------------------------------
package propose_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,   // clause loading happens inside IDLE so it costs no bubble; encoding kept reserved
    ST_ISSUE,
    ST_WAIT,
    ST_COMMIT,
    ST_DONE
  } state_t;

  localparam int DEF_COEF_W   = 8;
  localparam int DEF_VAR_IDX  = 2;
  localparam int DEF_SLOT_W   = 4;
  localparam int DEF_CLS_IDX  = 3;

  // Clause word = one coefficient per variable plus the bias term.
  function automatic int calc_cw(input int var_idx_w, input int coef_w);
    return ((2 ** var_idx_w) + 1) * coef_w;
  endfunction

  function automatic int calc_aw(input int var_idx_w, input int slot_w);
    return (2 ** var_idx_w) * slot_w;
  endfunction

  localparam int CW       = ((2 ** DEF_VAR_IDX) + 1) * DEF_COEF_W;
  localparam int ASSIGN_W = (2 ** DEF_VAR_IDX) * DEF_SLOT_W;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 -> bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/propose_move_sequencer_selector.sv
// -----------------------------------------------------------------------------
// variable_index_selector
// Picks the variable that is moved next. The index register only changes on
// an advance pulse, so it stays stable for the whole ISSUE/WAIT/COMMIT window.
//   clk, rst  : clock, asynchronous active-high reset
//   advance   : step to the next index (one pulse per ISSUE entry)
//   restart   : a new run begins (round-robin restarts from 0)
//   index     : selected variable index
// Build option PROPOSE_SEQ_LFSR_SELECT_EN: index is taken from the low bits of
// a 16-bit Fibonacci LFSR instead of a round-robin counter.
// -----------------------------------------------------------------------------
module variable_index_selector
  import propose_seq_pkg::*;
#(
  parameter int INDEX_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               advance,
  input  logic               restart,
  output logic [INDEX_W-1:0] index
);

`ifdef PROPOSE_SEQ_LFSR_SELECT_EN
  logic [15:0] lfsr;
  logic [15:0] lfsr_next;

  // The LFSR free-runs across runs; restart has no effect in this mode.
  logic unused_restart;
  assign unused_restart = restart;

  assign lfsr_next = {lfsr[14:0], ^(lfsr & LFSR_TAPS)};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr  <= LFSR_SEED;
      index <= '0;
    end else if (advance) begin
      lfsr  <= lfsr_next;
      index <= lfsr_next[INDEX_W-1:0];
    end
  end
`else
  logic [INDEX_W-1:0] next_index;
  logic [INDEX_W-1:0] base_index;

  // Restart and the first advance arrive together, so the restart value must
  // be visible to the advance in that same cycle.
  assign base_index = restart ? '0 : next_index;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      next_index <= '0;
      index      <= '0;
    end else if (advance) begin
      index      <= base_index;
      next_index <= base_index + 1'b1;
    end else begin
      next_index <= base_index;
    end
  end
`endif

endmodule

// File: rtl/propose_move_sequencer.sv
// -----------------------------------------------------------------------------
// propose_move_sequencer
// Control stage in front of the corner-point proposer. In IDLE it streams
// clause words into the clause registers and tracks which slots are loaded.
// On start it runs in_num_moves single-variable moves: pick a variable, wait
// PROPOSE_LATENCY cycles for the proposer, write the truncated result back.
// Ports:
//   in_clk, in_reset                 clock, asynchronous active-high reset
//   in_clause_valid/out_clause_ready clause word handshake (ready only in IDLE)
//   in_clause_data, in_clause_last   clause word, end of clause set
//   in_initial_assignment            seed assignment, sampled on start
//   in_num_moves, in_start           move count and start pulse
//   out_busy, out_done               run in progress / one-cycle completion
//   out_clause_coefficients/_index   clause register write port
//   out_reduce_enable                one bit per loaded clause slot
//   out_variable_to_be_unchanced_index  variable being moved
//   out_assignment                   live assignment read by the proposer
//   in_new_assignment                proposer result
// Build option PROPOSE_SEQ_LFSR_SELECT_EN selects LFSR variable choice
// (see variable_index_selector); default is round-robin.
// -----------------------------------------------------------------------------
module propose_move_sequencer
  import propose_seq_pkg::*;
#(
  parameter int MAXIMUM_BIT_WIDTH_OF_COEFFICIENT    = 8,
  parameter int MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX = 2,
  parameter int MAX_BIT_WIDTH_OF_INTEGER_VARIABLE   = 4,
  parameter int MAX_BIT_WIDTH_OF_CLAUSES_INDEX      = 3,
  parameter int PROPOSE_LATENCY                     = 2,
  parameter int MOVE_COUNT_WIDTH                    = 8
) (
  input  logic in_clk,
  input  logic in_reset,
  input  logic in_clause_valid,
  output logic out_clause_ready,
  input  logic [(2**MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX+1)*MAXIMUM_BIT_WIDTH_OF_COEFFICIENT-1:0] in_clause_data,
  input  logic in_clause_last,
  input  logic [MAX_BIT_WIDTH_OF_INTEGER_VARIABLE*(2**MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX)-1:0] in_initial_assignment,
  input  logic [MOVE_COUNT_WIDTH-1:0] in_num_moves,
  input  logic in_start,
  output logic out_busy,
  output logic out_done,
  output logic [(2**MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX+1)*MAXIMUM_BIT_WIDTH_OF_COEFFICIENT-1:0] out_clause_coefficients,
  output logic [MAX_BIT_WIDTH_OF_CLAUSES_INDEX-1:0] out_clause_index,
  output logic [2**MAX_BIT_WIDTH_OF_CLAUSES_INDEX-1:0] out_reduce_enable,
  output logic [MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX-1:0] out_variable_to_be_unchanced_index,
  output logic [MAX_BIT_WIDTH_OF_INTEGER_VARIABLE*(2**MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX)-1:0] out_assignment,
  input  logic [MAXIMUM_BIT_WIDTH_OF_COEFFICIENT-1:0] in_new_assignment
);

  localparam int VI      = MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX;
  localparam int SW      = MAX_BIT_WIDTH_OF_INTEGER_VARIABLE;
  localparam int CI      = MAX_BIT_WIDTH_OF_CLAUSES_INDEX;
  localparam int NSLOT   = 2 ** CI;
  localparam int CWIDTH  = calc_cw(VI, MAXIMUM_BIT_WIDTH_OF_COEFFICIENT);
  localparam int AWIDTH  = calc_aw(VI, SW);
  localparam int WAIT_W  = (PROPOSE_LATENCY > 1) ? $clog2(PROPOSE_LATENCY) : 1;

  state_t                      state;
  state_t                      state_next;
  logic [CI:0]                 load_cnt;      // 0..NSLOT; MSB set means the set is full
  logic [NSLOT-1:0]            reduce_enable;
  logic [MOVE_COUNT_WIDTH-1:0] moves_left;
  logic [WAIT_W-1:0]           wait_cnt;
  logic [AWIDTH-1:0]           assignment;
  logic [VI-1:0]               var_index;

  logic clause_accept;
  logic clause_write;
  logic start_accept;
  logic advance;

  // Only the low SW bits of the proposer result fit into an assignment slot.
  logic unused_new_assignment_msbs;
  assign unused_new_assignment_msbs = ^in_new_assignment[MAXIMUM_BIT_WIDTH_OF_COEFFICIENT-1:SW];

  assign clause_accept = in_clause_valid & out_clause_ready;
  // Words beyond the last slot are accepted but dropped.
  assign clause_write  = clause_accept & ~load_cnt[CI];
  assign start_accept  = in_start & (state == ST_IDLE);

  // The write port is live only in the cycle a word is written; otherwise it
  // parks on the all-ones slot with zero coefficients.
  assign out_clause_index        = clause_write ? load_cnt[CI-1:0] : '1;
  assign out_clause_coefficients = clause_write ? in_clause_data : CWIDTH'(0);

  assign out_reduce_enable                  = reduce_enable;
  assign out_assignment                     = assignment;
  assign out_variable_to_be_unchanced_index = var_index;

  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) state <= ST_IDLE;
    else          state <= state_next;
  end

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next       = state;
    advance          = 1'b0;
    out_clause_ready = 1'b0;
    out_busy         = 1'b1;
    out_done         = 1'b0;
    unique case (state)
      ST_IDLE: begin
        out_clause_ready = 1'b1;
        out_busy         = 1'b0;
        if (start_accept) begin
          if (in_num_moves == '0) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_ISSUE;
            advance    = 1'b1;
          end
        end
      end
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT: begin
        if (wait_cnt == WAIT_W'(PROPOSE_LATENCY - 1)) state_next = ST_COMMIT;
      end
      ST_COMMIT: begin
        if (moves_left == MOVE_COUNT_WIDTH'(1)) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_ISSUE;
          advance    = 1'b1;
        end
      end
      ST_DONE: begin
        out_done   = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      load_cnt      <= '0;
      reduce_enable <= '0;
      moves_left    <= '0;
      wait_cnt      <= '0;
      assignment    <= '0;
    end else begin
      // The first word of a new set replaces the previous set's mask, so the
      // mask keeps showing the closed set until loading resumes.
      if (clause_write) begin
        reduce_enable <= ((load_cnt == '0) ? '0 : reduce_enable)
                         | (NSLOT'(1) << load_cnt[CI-1:0]);
      end

      if (clause_accept && in_clause_last) load_cnt <= '0;
      else if (clause_write)               load_cnt <= load_cnt + 1'b1;

      // A word in the same cycle as start is written first; start then
      // closes the set (this assignment overrides the load_cnt update above).
      if (start_accept) begin
        load_cnt   <= '0;
        assignment <= in_initial_assignment;
        moves_left <= in_num_moves;
      end

      wait_cnt <= (state == ST_WAIT) ? wait_cnt + 1'b1 : '0;

      if (state == ST_COMMIT) begin
        assignment[var_index*SW +: SW] <= in_new_assignment[SW-1:0];
        moves_left                     <= moves_left - 1'b1;
      end
    end
  end

  variable_index_selector #(
    .INDEX_W (VI)
  ) u_selector (
    .clk     (in_clk),
    .rst     (in_reset),
    .advance (advance),
    .restart (start_accept),
    .index   (var_index)
  );

endmodule
